// File: rtl/divider_pkg.sv
// Shared types and constants for the 8-bit by 4-bit restoring divider.
package divider_pkg;

  localparam int unsigned DIVIDEND_W = 8;
  localparam int unsigned DIVISOR_W  = 4;
  localparam int unsigned COUNT_W    = 3;

  localparam logic [DIVIDEND_W-1:0] QUOT_DZ = 8'hFF;
  localparam logic [DIVISOR_W-1:0]  REM_DZ  = 4'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/divider_datapath.sv
// Remainder/quotient registers and the one-bit-per-cycle restoring step.
module divider_datapath
  import divider_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift_step,
  input  logic                  dz_load,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  logic [DIVISOR_W:0]                  rem_q, rem_d;
  logic [DIVIDEND_W-1:0]               quot_q, quot_d;
  logic [DIVISOR_W-1:0]                dvsr_q, dvsr_d;
  logic                                dz_q, dz_d;
  logic [DIVISOR_W+DIVIDEND_W:0]       shifted;
  logic [DIVISOR_W:0]                  rem_sh;
  logic [DIVISOR_W:0]                  trial;

  // Partial remainder and quotient/dividend shift together as one register;
  // the 5-bit remainder cannot overflow since it stays below 2*divisor.
  always_comb begin
    shifted = {rem_q, quot_q} << 1;
    rem_sh  = shifted[DIVISOR_W+DIVIDEND_W:DIVIDEND_W];
    trial   = rem_sh - {1'b0, dvsr_q};
  end

  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    dvsr_d = dvsr_q;
    dz_d   = dz_q;
    if (load) begin
      rem_d  = '0;
      quot_d = dividend;
      dvsr_d = divisor;
      dz_d   = 1'b0;
    end else if (dz_load) begin
      rem_d  = {1'b0, REM_DZ};
      quot_d = QUOT_DZ;
      dz_d   = 1'b1;
    end else if (shift_step) begin
      if (rem_sh >= {1'b0, dvsr_q}) begin
        rem_d  = trial;
        quot_d = {shifted[DIVIDEND_W-1:1], 1'b1};
      end else begin
        rem_d  = rem_sh;
        quot_d = {shifted[DIVIDEND_W-1:1], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
      dz_q   <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvsr_q <= dvsr_d;
      dz_q   <= dz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q[DIVISOR_W-1:0];
  assign div_by_zero = dz_q;

endmodule

// File: rtl/divider.sv
// Divider control: IDLE/CALC/DONE sequencer and step counter driving the datapath.
module divider
  import divider_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               load, shift_step, dz_load;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    load       = 1'b0;
    shift_step = 1'b0;
    dz_load    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            load    = 1'b1;
            count_d = '0;
            state_d = CALC;
          end else begin
            dz_load = 1'b1;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        busy       = 1'b1;
        shift_step = 1'b1;
        count_d    = count_q + 1'b1;
        if (count_q == '1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  divider_datapath u_datapath (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .shift_step  (shift_step),
    .dz_load     (dz_load),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

endmodule

// File: tb/tb_divider.sv
// Directed and exhaustive checks of divider results, latency, and reset/start corner cases.
module tb_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int errors = 0;
  int checks = 0;

  divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dd;
    logic [3:0] dv;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the edge following done.
  task automatic run_op(input logic [7:0] dd, input logic [3:0] dv, input logic [7:0] eq,
                        input logic [3:0] er, input logic edz, input int elat, input string tag);
    int lat;
    lat      = 0;
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, div_by_zero, edz);
    check({tag, " busy at done"}, busy, 1);
    @(posedge clk); #1;
    check({tag, " done pulse ends"}, {busy, done}, 0);
  endtask

  initial begin
    int ndone;
    int dlat;
    logic [7:0] qd;
    logic [3:0] rd;

    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int dlat;
    logic [7:0] qd;
    logic [3:0] rd;

    vecs[0]  = '{8'd100, 4'd7,  8'd14,  4'd2, 1'b0, 9};
    vecs[1]  = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 9};
    vecs[2]  = '{8'd5,   4'd9,  8'd0,   4'd5, 1'b0, 9};
    vecs[3]  = '{8'd42,  4'd0,  8'hFF,  4'd0, 1'b1, 1};
    vecs[4]  = '{8'd42,  4'd6,  8'd7,   4'd0, 1'b0, 9};
    vecs[5]  = '{8'd0,   4'd5,  8'd0,   4'd0, 1'b0, 9};
    vecs[6]  = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 9};
    vecs[7]  = '{8'd1,   4'd1,  8'd1,   4'd0, 1'b0, 9};
    vecs[8]  = '{8'd254, 4'd13, 8'd19,  4'd7, 1'b0, 9};
    vecs[9]  = '{8'd128, 4'd3,  8'd42,  4'd2, 1'b0, 9};
    vecs[10] = '{8'd0,   4'd0,  8'hFF,  4'd0, 1'b1, 1};
    vecs[11] = '{8'd14,  4'd15, 8'd0,   4'd14, 1'b0, 9};

    rst      = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #2;
    check("reset outputs", {quotient, remainder, busy, done, div_by_zero}, 0);
    #10 rst = 1'b1;
    @(posedge clk); #1;
    check("idle after reset", {busy, done}, 0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].dd, vecs[i].dv, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat,
             $sformatf("vec%0d", i));
    end

    // Restart attempts and operand changes during CALC must not disturb 200/15.
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd15;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    dlat  = 0;
    qd    = '0;
    rd    = '0;
    for (int c = 1; c <= 14; c++) begin
      if (done) begin
        ndone++;
        if (dlat == 0) begin
          dlat = c;
          qd   = quotient;
          rd   = remainder;
        end
      end
      if (c >= 2 && c <= 4) begin
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 4'd3;
      end else begin
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
      end
      @(posedge clk); #1;
    end
    check("restart ignored done count", ndone, 1);
    check("restart ignored latency", dlat, 9);
    check("restart ignored quotient", qd, 13);
    check("restart ignored remainder", rd, 5);

    // A start presented only in the DONE cycle is lost; results hold in IDLE.
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("50/5 done in cycle 9", done, 1);
    start    = 1'b1;
    dividend = 8'd30;
    divisor  = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    check("start in DONE lost", busy, 0);
    @(posedge clk); #1;
    check("still idle after lost start", busy, 0);
    check("quotient held", quotient, 10);
    check("remainder held", remainder, 0);

    // Asynchronous reset in CALC count=4 aborts with no done pulse.
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("busy before abort", busy, 1);
    #3 rst = 1'b0;
    #1;
    check("abort quotient", quotient, 0);
    check("abort remainder", remainder, 0);
    check("abort flags", {busy, done, div_by_zero}, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("no done during reset", {busy, done}, 0);
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("no done after release", {busy, done}, 0);
    run_op(8'd17, 4'd4, 8'd4, 4'd1, 1'b0, 9, "post-reset 17/4");

    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0, 9, $sformatf("sweep %0d/%0d", a, b));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have a port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have a port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-003 The block SHALL have a port start, input, 1 bit: request a division, sampled only in IDLE.
REQ-004 The block SHALL have a port dividend, input, 8 bits: unsigned numerator, captured on the accepting edge.
REQ-005 The block SHALL have a port divisor, input, 4 bits: unsigned denominator, captured on the accepting edge.
REQ-006 The block SHALL have a port quotient, output, 8 bits: unsigned result, registered.
REQ-007 The block SHALL have a port remainder, output, 4 bits: unsigned result, registered.
REQ-008 The block SHALL have a port busy, output, 1 bit: high in CALC and DONE.
REQ-009 The block SHALL have a port done, output, 1 bit: one-cycle pulse, high only in DONE.
REQ-010 The block SHALL have a port div_by_zero, output, 1 bit: registered flag for the last accepted operation.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-012 In IDLE with start=1 and divisor!=0, the edge SHALL latch the operands, clear the partial remainder, set count=0, clear div_by_zero and go to CALC.
REQ-013 In IDLE with start=1 and divisor=0, the edge SHALL set quotient=8'hFF, remainder=4'h0 and div_by_zero=1, and go directly to DONE.
REQ-014 Each CALC cycle SHALL perform one restoring step, as follows:
- Shift the 5-bit partial remainder and the 8-bit quotient/dividend shift register left by one as a single concatenated register.
- Compute the 5-bit trial value (partial remainder - {1'b0,divisor}).
- If the trial value is non-negative, load it into the partial remainder and set the quotient LSB to 1.
- Otherwise, keep the partial remainder and set the quotient LSB to 0.
REQ-015 The partial remainder SHALL be 5 bits wide so the shifted value (max 2*divisor-1 = 29) cannot overflow; remainder SHALL equal its low 4 bits.
REQ-016 CALC SHALL last exactly 8 cycles (count 0..7); on count=7 the FSM SHALL go to DONE.
REQ-017 DONE SHALL last exactly one cycle, then go to IDLE unconditionally.
REQ-018 Latency SHALL be fixed: done is high in the 9th cycle after the accepting edge for divisor!=0, and in the 1st cycle for divisor=0.
REQ-019 quotient, remainder and div_by_zero SHALL be valid when done=1.
REQ-020 quotient, remainder and div_by_zero SHALL hold until the next accepted start.
REQ-021 The result SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for every nonzero divisor.
REQ-022 start SHALL be ignored in CALC and DONE; operand changes during CALC SHALL NOT affect the result.
REQ-023 A start arriving in DONE SHALL be lost; start is accepted only in the IDLE cycle that follows DONE.
REQ-024 busy SHALL be 0 and done SHALL be 0 in IDLE.

Reset
REQ-025 While rst=0, the block SHALL asynchronously reset, regardless of clk, as follows:
- state=IDLE, count=0;
- quotient=8'h00, remainder=4'h0;
- busy=0, done=0, div_by_zero=0.
REQ-026 Reset asserted mid-CALC or in DONE SHALL abort the operation with no done pulse.
REQ-027 After the first clk edge with rst=1, the block SHALL accept start.

Structure
REQ-028 A shared package divider_pkg SHALL hold:
- the state enum (IDLE, CALC, DONE);
- DIVIDEND_W=8, DIVISOR_W=4, COUNT_W=3;
- the divide-by-zero constants QUOT_DZ=8'hFF and REM_DZ=4'h0.
REQ-029 The block SHALL split control from datapath, consistent with the existing shift-add multiplier.
REQ-030 Control (FSM, counter, busy/done) SHALL stay in divider.
REQ-031 One sub-module divider_datapath SHALL hold the remainder and quotient registers and the subtract/compare logic.
REQ-032 divider_datapath SHALL be driven by load, shift_step and dz_load strobes and SHALL return no status other than the registers' contents.

Verification
REQ-033 The bench SHALL cover: dividend=100, divisor=7, start for 1 cycle -> done in cycle 9, quotient=14, remainder=2, div_by_zero=0.
REQ-034 The bench SHALL cover: dividend=255, divisor=1 -> quotient=255, remainder=0; then dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-035 The bench SHALL cover: dividend=42, divisor=0 -> done in cycle 1, quotient=8'hFF, remainder=0, div_by_zero=1; a following 42/6 -> div_by_zero=0, quotient=7, remainder=0.
REQ-036 The bench SHALL cover: start 200/15, then re-pulse start with 9/3 and change operands during CALC -> single done, quotient=13, remainder=5.
REQ-037 The bench SHALL cover: rst=0 in CALC count=4 -> immediate IDLE, outputs zero, no done; after release, 17/4 -> quotient=4, remainder=1.
REQ-038 The bench SHALL run an exhaustive sweep, all 256x15 nonzero-divisor pairs, back-to-back, checked against a reference model for quotient, remainder and latency.
